pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder. Successor to the team's fixed 8-bit zero-carry-in adder.
- Splits a WIDTH-bit addition into STAGES equal carry-chained chunks, with one register stage per chunk.
- Carries a valid/ready handshake with full backpressure, so arithmetic datapaths (score/counter units) can stream operands at one result per clock.
- Supports an external carry-in.

Parameters:
- WIDTH, 8: operand width in bits. WIDTH % STAGES must be 0; otherwise elaboration fails.
- STAGES, 2: pipeline depth (1..WIDTH). Chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B.
- cin  in  1  carry-in for bit 0.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- out  out  WIDTH+1  sum; out[WIDTH] = final carry-out.

Behaviour:
- Reset (resetn=0, asynchronous, any time including mid-stream):
  - All stage valid bits clear; in-flight beats are discarded.
  - out_valid=0, out=0.
  - in_ready=1 from the first cycle after release.
- Pipeline state per stage k (0..STAGES-1): valid_k, partial sum bits [(k+1)*CW-1:0], carry_k, and the not-yet-added upper operand chunks of A and B.
- Stage 0 computes chunk 0 as in0[CW-1:0]+in1[CW-1:0]+cin. Stage k adds chunk k of the forwarded operands plus carry_(k-1).
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid = valid_(STAGES-1); out = {carry, sum} of the last stage.
- Backpressure: stage k advances when !valid_k | ready_(k+1); ready_STAGES = out_ready. in_ready = ready_0 (combinational through the chain).
- A stage that is full and not advancing holds every bit unchanged. out must not change while out_valid=1 & out_ready=0.
- Latency: a beat accepted in cycle t is presented on out in cycle t+STAGES when there is no stall.
- Throughput: 1 beat per cycle while out_ready=1. Simultaneous input and output transfer on a full pipe is legal and loses nothing.
- Stalls:
  - A full pipe holds at most STAGES beats.
  - in_ready=0 when all stages are full and out_ready=0.
  - Order is strictly preserved.
- Arithmetic is unsigned modulo 2^(WIDTH+1). No overflow flag; out[WIDTH] is the carry.
- STAGES=1 gives a single registered adder with latency 1.
- in0/in1/cin are don't-care when in_valid=0 and are never sampled then.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds port `sub` (in, 1), sampled with the operands.
  - When sub=1 the block computes in0 + ~in1 + 1 and ignores cin.
  - out[WIDTH]=1 means no borrow (in0>=in1); out[WIDTH]=0 means borrow.
  - The sub bit travels with its beat, so mixed add/sub streams are legal back to back.
- Undefined: no `sub` port; behaviour is addition only, exactly as above.

Decomposition:
- Shared package adder_pkg:
  - default width constant ADDER_W_DEFAULT=8;
  - default depth constant ADDER_STAGES_DEFAULT=2;
  - chunk-width helper function/constant expression.
- One natural sub-module: adder_stage, a combinational CW-bit chunk adder (chunk A, chunk B, carry in -> CW-bit sum, carry out).
  - Instantiated STAGES times in a generate loop.
  - Registers and handshake stay in pipelined_adder.
  - Replaces the per-bit full adder instantiation style.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: in0=0xFF, in1=0x01, cin=0 -> out=0x100 with out_valid exactly 2 cycles after acceptance.
- Carry across chunk boundary: in0=0x0F, in1=0x01, cin=0 -> out=0x010. Then in0=0x7F, in1=0x80, cin=1 -> out=0x100, on consecutive cycles.
- Backpressure: out_ready=0, send 0x01+0x01, 0x02+0x02, 0x03+0x03.
  - in_ready drops after two accepts.
  - Raising out_ready yields 0x002, 0x004, 0x006 in order, none lost or duplicated.
- Reset mid-operation: two beats in flight, pulse resetn low between clock edges -> out_valid and out go to 0 immediately; no stale beat emerges after release.
- Streaming throughput: 16 random back-to-back beats with out_ready=1 -> 16 results on 16 consecutive cycles, each matching a reference model.
- PIPELINED_ADDER_SUB_EN defined:
  - sub=1, in0=0x05, in1=0x07 -> out=0x0FE (borrow, out[8]=0);
  - sub=1, in0=0x07, in1=0x05 -> out=0x102.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
package adder_pkg;
   localparam int ADDER_W_DEFAULT      = 8;
   localparam int ADDER_STAGES_DEFAULT = 2;

   function automatic int chunk_w(input int w, input int s);
      return w / s;
   endfunction
endpackage

// File: rtl/adder_stage.sv
// Combinational CW-bit chunk adder: one link of the pipelined carry chain.
module adder_stage #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          ci,
   output logic [CW-1:0] s,
   output logic          co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one register bank per CW-bit chunk, valid/ready throughout.
// Optional subtract mode (in0 - in1, out[WIDTH]=1 means no borrow) under PIPELINED_ADDER_SUB_EN.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = ADDER_W_DEFAULT,
   parameter int STAGES = ADDER_STAGES_DEFAULT
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out
);
   localparam int CW = chunk_w(WIDTH, STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   logic [STAGES:0] vld_pipe;
   logic [STAGES:0] rdy;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

   // Subtraction is folded in at the entry, so the mode travels with the beat for free.
`ifdef PIPELINED_ADDER_SUB_EN
   assign b_in = sub ? ~in1 : in1;
   assign c_in = sub | cin;
`else
   assign b_in = in1;
   assign c_in = cin;
`endif

   assign vld_pipe[0] = in_valid;

   always_comb begin
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         rdy[k] = ~vld_pipe[k+1] | rdy[k+1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : stg
      // Operand bits still to be added when the beat enters this stage.
      localparam int R = WIDTH - k*CW;

      logic [R-1:0]          a_cur, b_cur;
      logic                  c_cur;
      logic [CW-1:0]         s_ch;
      logic                  co;
      logic [(k+1)*CW-1:0]   s_nx, s_q;
      logic                  v_q, c_q, load;

      assign load          = rdy[k] & vld_pipe[k];
      assign vld_pipe[k+1] = v_q;

      if (k == 0) begin : g_src
         assign a_cur = in0;
         assign b_cur = b_in;
         assign c_cur = c_in;
         assign s_nx  = s_ch;
      end else begin : g_src
         // Remaining operand chunks sit in the previous bank, loaded alongside its sum.
         logic [R-1:0] a_r, b_r;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               a_r <= '0;
               b_r <= '0;
            end else if (stg[k-1].load) begin
               a_r <= stg[k-1].a_cur[R+CW-1:CW];
               b_r <= stg[k-1].b_cur[R+CW-1:CW];
            end
         end
         assign a_cur = a_r;
         assign b_cur = b_r;
         assign c_cur = stg[k-1].c_q;
         assign s_nx  = {s_ch, stg[k-1].s_q};
      end

      adder_stage #(.CW(CW)) u_add (
         .a  (a_cur[CW-1:0]),
         .b  (b_cur[CW-1:0]),
         .ci (c_cur),
         .s  (s_ch),
         .co (co)
      );

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else begin
            if (rdy[k]) v_q <= vld_pipe[k];
            if (load) begin
               c_q <= co;
               s_q <= s_nx;
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld_pipe[STAGES];
   assign out       = {stg[STAGES-1].c_q, stg[STAGES-1].s_q};
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=8, STAGES=2 (subtract vectors under PIPELINED_ADDER_SUB_EN).
module tb_pipelined_adder;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in0 = '0, in1 = '0;
   logic       cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
   logic       sub = 1'b0;
`endif
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [8:0] dout;

   int total = 0;
   int bad   = 0;
   logic [8:0] expq [16];

   pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c);
      in_valid = 1'b1;
      in0 = a;
      in1 = b;
      cin = c;
   endtask

   initial begin
      // reset state
      step();
      check("rst_out_valid", {8'h0, out_valid}, 9'h0);
      check("rst_out", dout, 9'h000);
      resetn = 1'b1;
      step();
      check("rst_in_ready", {8'h0, in_ready}, 9'h1);

      // single beat, latency 2
      drive(8'hFF, 8'h01, 1'b0);
      check("lat_in_ready", {8'h0, in_ready}, 9'h1);
      step();
      in_valid = 1'b0;
      check("lat_not_early", {8'h0, out_valid}, 9'h0);
      step();
      check("lat_valid", {8'h0, out_valid}, 9'h1);
      check("lat_sum", dout, 9'h100);
      step();
      check("lat_drain", {8'h0, out_valid}, 9'h0);

      // chunk-boundary carries, back to back
      drive(8'h0F, 8'h01, 1'b0);
      step();
      drive(8'h7F, 8'h80, 1'b1);
      step();
      in_valid = 1'b0;
      check("carry0_valid", {8'h0, out_valid}, 9'h1);
      check("carry0_sum", dout, 9'h010);
      step();
      check("carry1_valid", {8'h0, out_valid}, 9'h1);
      check("carry1_sum", dout, 9'h100);
      step();

      // backpressure: pipe fills after two beats and holds
      out_ready = 1'b0;
      drive(8'h01, 8'h01, 1'b0);
      check("bp_rdy0", {8'h0, in_ready}, 9'h1);
      step();
      drive(8'h02, 8'h02, 1'b0);
      check("bp_rdy1", {8'h0, in_ready}, 9'h1);
      step();
      drive(8'h03, 8'h03, 1'b0);
      check("bp_full", {8'h0, in_ready}, 9'h0);
      step();
      check("bp_still_full", {8'h0, in_ready}, 9'h0);
      check("bp_hold_valid", {8'h0, out_valid}, 9'h1);
      check("bp_hold0", dout, 9'h002);
      step();
      check("bp_hold1", dout, 9'h002);
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", {8'h0, in_ready}, 9'h1);
      step();
      in_valid = 1'b0;
      check("bp_out1_valid", {8'h0, out_valid}, 9'h1);
      check("bp_out1", dout, 9'h004);
      step();
      check("bp_out2_valid", {8'h0, out_valid}, 9'h1);
      check("bp_out2", dout, 9'h006);
      step();
      check("bp_empty", {8'h0, out_valid}, 9'h0);

      // asynchronous reset with two beats in flight
      out_ready = 1'b0;
      drive(8'h10, 8'h20, 1'b0);
      step();
      drive(8'h30, 8'h01, 1'b0);
      step();
      in_valid = 1'b0;
      check("mid_pre_sum", dout, 9'h030);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_valid", {8'h0, out_valid}, 9'h0);
      check("mid_rst_out", dout, 9'h000);
      #1 resetn = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_stale", {8'h0, out_valid}, 9'h0);
      end

      // 16 random beats streamed back to back
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom));
            expq[i] = {1'b0, in0} + {1'b0, in1} + {8'h0, cin};
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i >= 1) begin
            check("stream_valid", {8'h0, out_valid}, 9'h1);
            check("stream_sum", dout, expq[i-1]);
         end
      end
      step();
      check("stream_drain", {8'h0, out_valid}, 9'h0);

`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'b1;
      drive(8'h05, 8'h07, 1'b0);
      step();
      drive(8'h07, 8'h05, 1'b0);
      step();
      in_valid = 1'b0;
      sub = 1'b0;
      check("sub_borrow", dout, 9'h0FE);
      step();
      check("sub_noborrow", dout, 9'h102);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
